// File: rtl/pipelined_ripple_subtractor.sv
// Pipelined ripple-borrow subtractor: D = A - B - bin, split into STAGES chunks
// with a register after each chunk, plus input and output registers.
module pipelined_ripple_subtractor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             V
);

  localparam int unsigned CW  = WIDTH / STAGES;
  localparam int unsigned NS  = STAGES + 1;
  localparam int unsigned MSB = WIDTH - 1;

  generate
    if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_ripple_subtractor: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Stage s holds operands, partial difference and borrow after s chunks.
  logic [WIDTH-1:0] a_q   [NS];
  logic [WIDTH-1:0] a_d   [NS];
  logic [WIDTH-1:0] b_q   [NS];
  logic [WIDTH-1:0] b_d   [NS];
  logic [WIDTH-1:0] dif_q [NS];
  logic [WIDTH-1:0] dif_d [NS];
  logic             br_q  [NS];
  logic             br_d  [NS];
  logic             vld_q [NS];
  logic             vld_d [NS];

  logic [WIDTH-1:0] dif_tmp;
  logic             br_tmp;
  logic             a_bit;
  logic             b_bit;

  // Input capture plus one ripple-borrow chunk per pipeline step.
  always_comb begin
    dif_tmp = '0;
    br_tmp  = 1'b0;
    a_bit   = 1'b0;
    b_bit   = 1'b0;
    a_d[0]   = A;
    b_d[0]   = B;
    dif_d[0] = '0;
    br_d[0]  = bin;
    vld_d[0] = in_valid;
    for (int k = 0; k < int'(STAGES); k++) begin
      dif_tmp = dif_q[k];
      br_tmp  = br_q[k];
      for (int i = 0; i < int'(CW); i++) begin
        a_bit = a_q[k][k*int'(CW) + i];
        b_bit = b_q[k][k*int'(CW) + i];
        dif_tmp[k*int'(CW) + i] = a_bit ^ b_bit ^ br_tmp;
        br_tmp = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_tmp);
      end
      a_d[k+1]   = a_q[k];
      b_d[k+1]   = b_q[k];
      dif_d[k+1] = dif_tmp;
      br_d[k+1]  = br_tmp;
      vld_d[k+1] = vld_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(NS); s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        dif_q[s] <= '0;
        br_q[s]  <= 1'b0;
        vld_q[s] <= 1'b0;
      end
      out_valid <= 1'b0;
      D         <= '0;
      bout      <= 1'b0;
      V         <= 1'b0;
    end else begin
      for (int s = 0; s < int'(NS); s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        dif_q[s] <= dif_d[s];
        br_q[s]  <= br_d[s];
        vld_q[s] <= vld_d[s];
      end
      out_valid <= vld_q[STAGES];
      // Result registers only move for real operations; bubbles leave them alone.
      if (vld_q[STAGES]) begin
        D    <= dif_q[STAGES];
        bout <= br_q[STAGES];
        V    <= (a_q[STAGES][MSB] ^ b_q[STAGES][MSB]) &
                (dif_q[STAGES][MSB] ^ a_q[STAGES][MSB]);
      end
    end
  end

endmodule

// File: tb/tb_pipelined_ripple_subtractor.sv
// Bench for pipelined_ripple_subtractor: three instances (STAGES 1/2/4) share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_pipelined_ripple_subtractor;

  localparam int HMAX = 4096;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       bin;

  logic       ov_w [3];
  logic [3:0] d_w  [3];
  logic       bo_w [3];
  logic       v_w  [3];

  pipelined_ripple_subtractor #(.WIDTH(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .bin(bin),
    .out_valid(ov_w[0]), .D(d_w[0]), .bout(bo_w[0]), .V(v_w[0]));
  pipelined_ripple_subtractor #(.WIDTH(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .bin(bin),
    .out_valid(ov_w[1]), .D(d_w[1]), .bout(bo_w[1]), .V(v_w[1]));
  pipelined_ripple_subtractor #(.WIDTH(4), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .bin(bin),
    .out_valid(ov_w[2]), .D(d_w[2]), .bout(bo_w[2]), .V(v_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  // History of what was sampled on each edge, indexed by edge number.
  logic       hv  [HMAX];
  logic [3:0] ha  [HMAX];
  logic [3:0] hb  [HMAX];
  logic       hbi [HMAX];
  int         e = 0;
  int         last_rst = -1;

  logic       m_ov [3];
  logic [3:0] m_d  [3];
  logic       m_bo [3];
  logic       m_v  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic int lat(input int j);
    return (j == 0) ? 2 : ((j == 1) ? 3 : 5);
  endfunction

  function automatic int to_signed4(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic bi, input logic r);
    int src;
    int diff;
    int sdiff;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    bin      = bi;
    @(posedge clk);
    if (e >= HMAX) begin
      $display("FAIL history_overflow got=%0d want<%0d", e, HMAX);
      $fatal(1, "history overflow");
    end
    hv[e]  = v;
    ha[e]  = a;
    hb[e]  = b;
    hbi[e] = bi;
    if (r) last_rst = e;
    #1;
    for (int j = 0; j < 3; j++) begin
      src = e - lat(j);
      if (r) begin
        m_ov[j] = 1'b0;
        m_d[j]  = 4'd0;
        m_bo[j] = 1'b0;
        m_v[j]  = 1'b0;
      end else if (src >= 0 && src > last_rst && hv[src]) begin
        diff    = int'(ha[src]) - int'(hb[src]) - int'(hbi[src]);
        sdiff   = to_signed4(ha[src]) - to_signed4(hb[src]) - int'(hbi[src]);
        m_ov[j] = 1'b1;
        m_d[j]  = 4'(diff);
        m_bo[j] = (diff < 0);
        m_v[j]  = (sdiff < -8) || (sdiff > 7);
      end else begin
        m_ov[j] = 1'b0;
      end
      chk($sformatf("ov_s%0d", j), 32'(ov_w[j]), 32'(m_ov[j]));
      chk($sformatf("d_s%0d", j),  32'(d_w[j]),  32'(m_d[j]));
      chk($sformatf("bo_s%0d", j), 32'(bo_w[j]), 32'(m_bo[j]));
      chk($sformatf("v_s%0d", j),  32'(v_w[j]),  32'(m_v[j]));
    end
    e++;
  endtask

  task automatic idle();
    step(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
  endtask

  // One operation, then check the STAGES=2 instance against hand-worked values.
  task automatic dir_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic bi, input logic [3:0] ed, input logic ebo,
                        input logic ev);
    step(1'b1, a, b, bi, 1'b0);
    idle();
    idle();
    chk({tag, "_early"}, 32'(ov_w[1]), 32'd0);
    idle();
    chk({tag, "_ov"}, 32'(ov_w[1]), 32'd1);
    chk({tag, "_d"},  32'(d_w[1]),  32'(ed));
    chk({tag, "_bo"}, 32'(bo_w[1]), 32'(ebo));
    chk({tag, "_v"},  32'(v_w[1]),  32'(ev));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    bin = 1'b0;

    step(1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
    chk("rst_ov", 32'(ov_w[1]), 32'd0);
    chk("rst_d",  32'(d_w[1]),  32'd0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    idle();

    dir_op("basic",   4'b1001, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0);
    dir_op("brw_ovf", 4'b0101, 4'b1010, 1'b1, 4'b1010, 1'b1, 1'b1);
    dir_op("bin_rip", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
    dir_op("neg_ovf", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);

    // Back-to-back operations.
    step(1'b1, 4'b0110, 4'b0011, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 4'b0011, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 4'b0111, 1'b1, 1'b0);
    idle();
    chk("thr0_ov", 32'(ov_w[1]), 32'd1);
    chk("thr0_d",  32'(d_w[1]),  32'b0011);
    idle();
    chk("thr1_ov", 32'(ov_w[1]), 32'd1);
    chk("thr1_d",  32'(d_w[1]),  32'b0010);
    idle();
    chk("thr2_ov", 32'(ov_w[1]), 32'd1);
    chk("thr2_d",  32'(d_w[1]),  32'b1100);
    chk("thr2_bo", 32'(bo_w[1]), 32'd1);
    chk("thr2_v",  32'(v_w[1]),  32'd0);
    idle();
    chk("thr_end_ov", 32'(ov_w[1]), 32'd0);
    chk("thr_hold_d", 32'(d_w[1]),  32'b1100);

    // Bubbles with garbage data on idle cycles.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      else idle();
    end
    repeat (6) idle();

    // Reset while two operations are in flight.
    step(1'b1, 4'h7, 4'h2, 1'b0, 1'b0);
    step(1'b1, 4'h3, 4'h9, 1'b1, 1'b0);
    step(1'b1, 4'h5, 4'h5, 1'b0, 1'b1);
    chk("mid_rst_ov", 32'(ov_w[1]), 32'd0);
    chk("mid_rst_d",  32'(d_w[1]),  32'd0);
    chk("mid_rst_bo", 32'(bo_w[1]), 32'd0);
    chk("mid_rst_v",  32'(v_w[1]),  32'd0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("post_rst_quiet", 32'(ov_w[1]), 32'd0);
    end
    dir_op("post_rst", 4'b1100, 4'b0101, 1'b1, 4'b0110, 1'b0, 1'b1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 63) == 0));
    end
    repeat (6) idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
